ext_val_update_ctrl: RTL and testbench

Read-modify-write sequencer for the flow extreme-value feature cache. It accepts per-packet records (flow id, packet size, inter-arrival time), reads the flow's stored word through the cache's 2-cycle read port, and merges in new max/min values and the packet-size history vector. It writes the result back and reports it downstream. On reset it clears the whole cache. It blocks same-flow read-after-write hazards by stalling the input.

---
 rtl/ext_val_update_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ext_val_update_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_val_update_ctrl.sv
// Read-modify-write sequencer for the flow extreme-value feature cache; clears the cache on reset.
// Build option EXT_VAL_VEC_HIST_EN: the vector becomes an oldest-out byte-shift size history.
module ext_val_update_ctrl #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned VEC_W  = 160
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pkt_v,
   output logic                pkt_rdy,
   input  logic [ADDR_W-1:0]   pkt_flow_id,
   input  logic [7:0]          pkt_size,
   input  logic [7:0]          pkt_arit,
   input  logic                pkt_first,
   output logic                rd_mem,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [7:0]          c_max_pkt_size,
   input  logic [7:0]          c_min_pkt_size,
   input  logic [7:0]          c_max_pkt_arit,
   input  logic [7:0]          c_min_pkt_arit,
   input  logic [VEC_W-1:0]    c_vec_feature,
   input  logic                c_rd_data_v,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [VEC_W+31:0]   wr_data,
   output logic                wea,
   output logic                upd_v,
   output logic [ADDR_W-1:0]   upd_flow_id,
   output logic [VEC_W+31:0]   upd_data,
   output logic                init_done,
   output logic                err_sync
);

   localparam int unsigned WordW = VEC_W + 32;
   localparam logic [ADDR_W:0] ClrEnd = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic {StInit, StRun} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
   logic                wea_q, wea_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [WordW-1:0]    wr_data_q, wr_data_d;
   logic                err_q, err_d;

   logic                s1_v_q, s2_v_q;
   logic [ADDR_W-1:0]   s1_flow_q, s2_flow_q;
   logic [7:0]          s1_size_q, s2_size_q;
   logic [7:0]          s1_arit_q, s2_arit_q;
   logic                s1_first_q, s2_first_q;

   logic                run;
   logic                hazard;
   logic                accept;
   logic [7:0]          mx_size, mn_size, mx_arit, mn_arit;
   logic [VEC_W-1:0]    vec_new;
   logic [WordW-1:0]    merge_word;

   assign run = (state_q == StRun);

   // The write register doubles as stage S3, so its address covers the third hazard slot.
   assign hazard = (s1_v_q && (s1_flow_q == pkt_flow_id)) ||
                   (s2_v_q && (s2_flow_q == pkt_flow_id)) ||
                   (wea_q && run && (wr_addr_q == pkt_flow_id));

   assign pkt_rdy = run & ~hazard;
   assign accept  = pkt_v & pkt_rdy;
   assign rd_mem  = accept;
   assign rd_addr = accept ? pkt_flow_id : '0;

   always_comb begin
      mx_size = s2_size_q;
      mn_size = s2_size_q;
      mx_arit = 8'h00;
      mn_arit = 8'hFF;
      vec_new = '0;
      if (s2_first_q) begin
`ifdef EXT_VAL_VEC_HIST_EN
         vec_new = VEC_W'(s2_size_q);
`else
         vec_new = '0;
`endif
      end else begin
         mx_size = (c_max_pkt_size > s2_size_q) ? c_max_pkt_size : s2_size_q;
         mn_size = (c_min_pkt_size < s2_size_q) ? c_min_pkt_size : s2_size_q;
         mx_arit = (c_max_pkt_arit > s2_arit_q) ? c_max_pkt_arit : s2_arit_q;
         mn_arit = (c_min_pkt_arit < s2_arit_q) ? c_min_pkt_arit : s2_arit_q;
`ifdef EXT_VAL_VEC_HIST_EN
         vec_new = (c_vec_feature << 8) | VEC_W'(s2_size_q);
`else
         vec_new = c_vec_feature;
`endif
      end
   end

   assign merge_word = {vec_new, mx_size, mn_size, mx_arit, mn_arit};

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      wea_d     = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      unique case (state_q)
         StInit: begin
            if (clr_cnt_q == ClrEnd) begin
               state_d = StRun;
            end else begin
               wea_d     = 1'b1;
               wr_addr_d = clr_cnt_q[ADDR_W-1:0];
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         StRun: begin
            wea_d     = s2_v_q;
            wr_addr_d = s2_flow_q;
            wr_data_d = merge_word;
         end
      endcase
   end

   // Merge still proceeds on a misaligned read; the flag only records it.
   assign err_d = err_q | (s2_v_q != c_rd_data_v);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StInit;
         clr_cnt_q <= '0;
         wea_q     <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         wea_q     <= wea_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q     <= 1'b0;
         s1_flow_q  <= '0;
         s1_size_q  <= '0;
         s1_arit_q  <= '0;
         s1_first_q <= 1'b0;
         s2_v_q     <= 1'b0;
         s2_flow_q  <= '0;
         s2_size_q  <= '0;
         s2_arit_q  <= '0;
         s2_first_q <= 1'b0;
      end else begin
         s1_v_q     <= accept;
         s1_flow_q  <= pkt_flow_id;
         s1_size_q  <= pkt_size;
         s1_arit_q  <= pkt_arit;
         s1_first_q <= pkt_first;
         s2_v_q     <= s1_v_q;
         s2_flow_q  <= s1_flow_q;
         s2_size_q  <= s1_size_q;
         s2_arit_q  <= s1_arit_q;
         s2_first_q <= s1_first_q;
      end
   end

   assign wea         = wea_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign upd_v       = wea_q & run;
   assign upd_flow_id = wr_addr_q;
   assign upd_data    = wr_data_q;
   assign init_done   = run;
   assign err_sync    = err_q;

endmodule

// File: tb/tb_ext_val_update_ctrl.sv
// Bench for ext_val_update_ctrl: behavioural cache plus per-flow reference words and an
// expected-update queue, driven by directed steps and a randomized phase.
module tb_ext_val_update_ctrl;

   localparam int unsigned AW    = 12;
   localparam int unsigned VW    = 160;
   localparam int unsigned WW    = VW + 32;
   localparam int unsigned Depth = 4096;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            pkt_v = 1'b0;
   logic            pkt_rdy;
   logic [AW-1:0]   pkt_flow_id = '0;
   logic [7:0]      pkt_size = '0;
   logic [7:0]      pkt_arit = '0;
   logic            pkt_first = 1'b0;
   logic            rd_mem;
   logic [AW-1:0]   rd_addr;
   logic [7:0]      c_max_pkt_size, c_min_pkt_size, c_max_pkt_arit, c_min_pkt_arit;
   logic [VW-1:0]   c_vec_feature;
   logic            c_rd_data_v;
   logic [AW-1:0]   wr_addr;
   logic [WW-1:0]   wr_data;
   logic            wea;
   logic            upd_v;
   logic [AW-1:0]   upd_flow_id;
   logic [WW-1:0]   upd_data;
   logic            init_done;
   logic            err_sync;

   ext_val_update_ctrl #(.ADDR_W(AW), .VEC_W(VW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pkt_v          (pkt_v),
      .pkt_rdy        (pkt_rdy),
      .pkt_flow_id    (pkt_flow_id),
      .pkt_size       (pkt_size),
      .pkt_arit       (pkt_arit),
      .pkt_first      (pkt_first),
      .rd_mem         (rd_mem),
      .rd_addr        (rd_addr),
      .c_max_pkt_size (c_max_pkt_size),
      .c_min_pkt_size (c_min_pkt_size),
      .c_max_pkt_arit (c_max_pkt_arit),
      .c_min_pkt_arit (c_min_pkt_arit),
      .c_vec_feature  (c_vec_feature),
      .c_rd_data_v    (c_rd_data_v),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wea            (wea),
      .upd_v          (upd_v),
      .upd_flow_id    (upd_flow_id),
      .upd_data       (upd_data),
      .init_done      (init_done),
      .err_sync       (err_sync)
   );

   initial forever #5 clk = ~clk;

   // Cache model: 2-cycle read latency; never-written words read back as address-derived junk.
   logic [WW-1:0] mem [Depth];
   bit            mem_v [Depth];
   logic          p0_v = 1'b0, p1_v = 1'b0;
   logic [WW-1:0] p0_d = '0, p1_d = '0;
   logic          kill_rdv = 1'b0;

   always @(posedge clk) begin
      if (wea) begin
         mem[wr_addr]   <= wr_data;
         mem_v[wr_addr] <= 1'b1;
      end
      p0_v <= rd_mem;
      p0_d <= mem_v[rd_addr] ? mem[rd_addr] : {6{32'(rd_addr) * 32'h9E3779B1}};
      p1_v <= p0_v;
      p1_d <= p0_d;
   end

   assign c_rd_data_v    = p1_v & ~kill_rdv;
   assign c_vec_feature  = p1_d[WW-1:32];
   assign c_max_pkt_size = p1_d[31:24];
   assign c_min_pkt_size = p1_d[23:16];
   assign c_max_pkt_arit = p1_d[15:8];
   assign c_min_pkt_arit = p1_d[7:0];

   typedef struct {
      int            due;
      logic [AW-1:0] flow;
      logic [WW-1:0] word;
   } exp_t;

   exp_t          expq[$];
   logic [AW:0]   hist[$];
   logic [WW-1:0] ref_word [Depth];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] ref_merge(input logic [WW-1:0] st, input logic [7:0] s,
                                               input logic [7:0] a, input logic first);
      logic [VW-1:0] vec;
      logic [7:0]    mxs, mns, mxa, mna;
      if (first) begin
         mxs = s;
         mns = s;
         mxa = 8'h00;
         mna = 8'hFF;
`ifdef EXT_VAL_VEC_HIST_EN
         vec = {152'b0, s};
`else
         vec = '0;
`endif
      end else begin
         mxs = (st[31:24] > s) ? st[31:24] : s;
         mns = (st[23:16] < s) ? st[23:16] : s;
         mxa = (st[15:8] > a) ? st[15:8] : a;
         mna = (st[7:0] < a) ? st[7:0] : a;
`ifdef EXT_VAL_VEC_HIST_EN
         vec = {st[WW-9:32], s};
`else
         vec = st[WW-1:32];
`endif
      end
      return {vec, mxs, mns, mxa, mna};
   endfunction

   // A flow is blocked while it was accepted in any of the previous three cycles.
   function automatic logic model_rdy(input logic [AW-1:0] f);
      foreach (hist[i]) if (hist[i][AW] && hist[i][AW-1:0] == f) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check_outputs();
      exp_t e;
      if (expq.size() > 0 && expq[0].due == cyc) begin
         e = expq.pop_front();
         chk("upd_v", upd_v, 1);
         chk("upd_flow_id", upd_flow_id, e.flow);
         chk("upd_data", upd_data, e.word);
         chk("wea", wea, 1);
         chk("wr_addr", wr_addr, e.flow);
         chk("wr_data", wr_data, e.word);
      end else begin
         chk("upd_v_idle", upd_v, 0);
         chk("wea_idle", wea, 0);
      end
   endtask

   task automatic tick(input logic v, input logic [AW-1:0] f, input logic [7:0] s,
                       input logic [7:0] a, input logic fi);
      logic rdy_exp, acc;
      @(negedge clk);
      cyc++;
      check_outputs();
      pkt_v       = v;
      pkt_flow_id = f;
      pkt_size    = s;
      pkt_arit    = a;
      pkt_first   = fi;
      #1;
      rdy_exp = model_rdy(f);
      chk("pkt_rdy", pkt_rdy, rdy_exp);
      acc = v & rdy_exp;
      chk("rd_mem", rd_mem, acc);
      if (acc) begin
         chk("rd_addr", rd_addr, f);
         ref_word[f] = ref_merge(ref_word[f], s, a, fi);
         expq.push_back('{cyc + 3, f, ref_word[f]});
      end
      hist.push_front({acc, f});
      if (hist.size() > 3) void'(hist.pop_back());
   endtask

   task automatic idle();
      tick(1'b0, '0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic rand_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] f;
         f = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, Depth - 1))
                                         : AW'($urandom_range(0, 7));
         tick($urandom_range(0, 9) < 7, f, 8'($urandom), 8'($urandom),
              $urandom_range(0, 3) == 0);
      end
   endtask

   // Resets with a record offered on flow 5, then walks the whole clear sequence.
   task automatic reset_and_init();
      @(negedge clk);
      pkt_v       = 1'b1;
      pkt_flow_id = 12'd5;
      pkt_first   = 1'b0;
      rst_n       = 1'b0;
      kill_rdv    = 1'b0;
      #1;
      chk("reset_ctrl", {pkt_rdy, rd_mem, rd_addr, wea, wr_addr, upd_v, upd_flow_id,
                         init_done, err_sync}, '0);
      chk("reset_wr_data", wr_data, '0);
      chk("reset_upd_data", upd_data, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      expq.delete();
      hist.delete();
      foreach (ref_word[i]) ref_word[i] = '0;
      for (int k = 0; k < Depth; k++) begin
         @(negedge clk);
         chk("init_clear", {wea, wr_addr, wr_data, pkt_rdy, rd_mem, init_done, upd_v},
             {1'b1, AW'(k), {WW{1'b0}}, 4'b0000});
      end
   endtask

   initial begin
      reset_and_init();

      // First RUN cycle
      idle();
      chk("init_done", init_done, 1);
      chk("rdy_after_init", pkt_rdy, 1);
      chk("err_after_init", err_sync, 0);

      // Flow 5: first packet, then a follow-up at the earliest legal slot
      tick(1'b1, 12'd5, 8'h40, 8'h10, 1'b1);
      idle();
      idle();
      idle();
      chk("f5_first_addr", wr_addr, 12'd5);
      chk("f5_first_lo", wr_data[31:0], 32'h4040_00FF);
      tick(1'b1, 12'd5, 8'h80, 8'h08, 1'b0);
      chk("f5_second_rdy", pkt_rdy, 1);
      idle();
      idle();
      idle();
      chk("f5_second_lo", wr_data[31:0], 32'h8040_0808);
`ifdef EXT_VAL_VEC_HIST_EN
      chk("f5_hist_bytes", wr_data[47:32], 16'h4080);
`else
      chk("f5_vec_kept", wr_data[WW-1:32], '0);
`endif

      // Flow 7 back-to-back with a flow-8 record slipped in
      tick(1'b1, 12'd7, 8'h11, 8'h22, 1'b1);
      chk("f7_accept", pkt_rdy, 1);
      tick(1'b1, 12'd8, 8'h33, 8'h44, 1'b1);
      chk("f8_accept", pkt_rdy, 1);
      tick(1'b1, 12'd7, 8'h55, 8'h66, 1'b0);
      chk("f7_block_t2", pkt_rdy, 0);
      tick(1'b1, 12'd7, 8'h55, 8'h66, 1'b0);
      chk("f7_block_t3", pkt_rdy, 0);
      tick(1'b1, 12'd7, 8'h55, 8'h66, 1'b0);
      chk("f7_accept_t4", pkt_rdy, 1);
      repeat (4) idle();

      // Four distinct flows on consecutive cycles
      for (int i = 0; i < 7; i++) begin
         if (i < 4) tick(1'b1, AW'(20 + i), 8'(i * 3 + 1), 8'(i + 9), 1'b1);
         else idle();
         if (i >= 3) chk("burst_upd", {upd_v, upd_flow_id}, {1'b1, AW'(17 + i)});
      end

      rand_ticks(400);
      repeat (4) idle();
      chk("err_clean", err_sync, 0);

      // Missing read-valid at the expected slot
      tick(1'b1, 12'd9, 8'h21, 8'h12, 1'b1);
      idle();
      idle();
      kill_rdv = 1'b1;
      idle();
      kill_rdv = 1'b0;
      chk("err_set", err_sync, 1);
      repeat (5) idle();
      chk("err_sticky", err_sync, 1);

      // Reset with records in flight
      tick(1'b1, 12'd30, 8'h01, 8'h02, 1'b1);
      tick(1'b1, 12'd31, 8'h03, 8'h04, 1'b1);
      reset_and_init();
      idle();
      chk("reinit_done", init_done, 1);
      chk("err_cleared", err_sync, 0);
      rand_ticks(60);
      repeat (4) idle();
      chk("err_clean_end", err_sync, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
